// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: bundles the fetch port, the load/store port and the
// memory-side strobe bus of the unified instruction/data memory arbiter.
// The slave modport is the arbiter's view; the master modport is the view
// of the surrounding pipeline and memory.
interface imem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  // Instruction-fetch requester
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  // Load/store requester
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  // Single-port synchronous memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port synchronous word memory between the
// instruction-fetch port (I) and the load/store port (D). Every access runs
// through a fixed IDLE -> ISSUE -> WAIT -> DONE sequence, so an access that
// wins arbitration in cycle 0 strobes memory in cycle 1 and acks in cycle 3.
// D has priority; after MAX_STARVE consecutive D grants with I waiting, I is
// forced through. All outputs are registered.
//
// Optional build macro IMEM_ARB_ALIGN_CHECK_EN: when defined, a granted
// access whose byte address is not word aligned skips the memory and
// completes with err=1 and rdata=0 on the normal timeline. When undefined,
// the low two address bits are ignored and i_err/d_err stay 0.
module imem_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic          clk,
  input  logic          reset,
  imem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic {WIN_I = 1'b0, WIN_D = 1'b1} win_t;

  localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

  // FSM state and access latch
  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  win_t              win_q, win_d;
  logic              we_q, we_d;
  logic              bad_q, bad_d;

  // Registered outputs
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              i_err_q, i_err_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              i_bad, d_bad, d_wins;

  // Upper address bits fold onto the 2**ADDR_W words; they are dropped here.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0],
                              bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

`ifdef IMEM_ARB_ALIGN_CHECK_EN
  assign i_bad = |bus.i_addr[1:0];
  assign d_bad = |bus.d_addr[1:0];
`else
  assign i_bad = 1'b0;
  assign d_bad = 1'b0;
`endif

  // D wins unless only I is asking, or I has already waited MAX_STARVE grants.
  assign d_wins = bus.d_req && (!bus.i_req || (starve_q < STARVE_LIM));

  // Next-state, latch and output values for the four-phase access sequence.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d     = state_q;
    starve_d    = starve_q;
    win_d       = win_q;
    we_d        = we_q;
    bad_d       = bad_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_err_d     = 1'b0;
    d_err_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_d = S_ISSUE;
          if (d_wins) begin
            win_d       = WIN_D;
            we_d        = bus.d_we;
            bad_d       = d_bad;
            mem_en_d    = !d_bad;
            mem_we_d    = bus.d_we && !d_bad;
            mem_addr_d  = bus.d_addr[ADDR_W+1:2];
            mem_wdata_d = bus.d_we ? bus.d_wdata : '0;
            if (bus.i_req) starve_d = starve_q + 4'd1;
          end else begin
            win_d       = WIN_I;
            we_d        = 1'b0;
            bad_d       = i_bad;
            mem_en_d    = !i_bad;
            mem_addr_d  = bus.i_addr[ADDR_W+1:2];
            starve_d    = '0;
          end
        end
      end

      // mem_en is high during this cycle; the strobe was registered on entry.
      S_ISSUE: state_d = S_WAIT;

      // Memory data is valid now: capture it and arm the winner's ack.
      S_WAIT: begin
        state_d = S_DONE;
        if (win_q == WIN_I) begin
          i_ack_d   = 1'b1;
          i_err_d   = bad_q;
          i_rdata_d = bad_q ? '0 : bus.mem_rdata;
        end else begin
          d_ack_d = 1'b1;
          d_err_d = bad_q;
          if (bad_q)      d_rdata_d = '0;
          else if (!we_q) d_rdata_d = bus.mem_rdata;
        end
      end

      // Ack is visible this cycle; requests are not looked at until IDLE.
      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, starvation counter and the latched access attributes.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
      win_q    <= WIN_I;
      we_q     <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      win_q    <= win_d;
      we_q     <= we_d;
      bad_q    <= bad_d;
    end
  end

  // Output registers; reset also cancels any ack still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_err_q     <= i_err_d;
      d_err_q     <= d_err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_err     = i_err_q;
  assign bus.d_err     = d_err_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: drives imem_arbiter with directed scenarios followed by
// random I/D traffic, against a transaction-level reference that decides
// each grant from the arbitration rules, places its strobe one cycle and its
// ack three cycles after the grant, and keeps a shadow copy of memory.
// Honours IMEM_ARB_ALIGN_CHECK_EN the same way the design does.
module tb_imem_arbiter;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 32;
  localparam int MAX_STARVE = 4;
  localparam int WORDS      = 1 << ADDR_W;
`ifdef IMEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STARVE(MAX_STARVE)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Memory behind the arbiter, with a backdoor port used only for preload.
  logic [DATA_W-1:0] ram [WORDS];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_idx;
  logic [DATA_W-1:0] bd_data;
  always @(posedge clk) begin
    if (bd_we) ram[bd_idx] <= bd_data;
    else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [DATA_W-1:0] ref_mem [WORDS];
  int                cyc = 0;
  int                free_at = 0;
  int                starve = 0;
  bit                m_active = 1'b0;
  bit                m_is_d, m_we, m_bad;
  int                m_arb;
  logic [ADDR_W-1:0] m_word;
  logic [31:0]       m_wdata, m_rd;
  logic [31:0]       exp_i_rdata, exp_d_rdata;
  int                ack_order [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Decide the grant (if any) for the inputs presented during this cycle.
  task automatic model_eval();
    logic [31:0] a;
    if (reset) begin
      m_active    = 1'b0;
      starve      = 0;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
      free_at     = cyc + 1;
      return;
    end
    if (cyc < free_at || !(bus.i_req || bus.d_req)) return;
    m_is_d = bus.d_req && (!bus.i_req || starve < MAX_STARVE);
    if (m_is_d) begin
      if (bus.i_req) starve++;
      a       = bus.d_addr;
      m_we    = bus.d_we;
      m_wdata = bus.d_we ? bus.d_wdata : 32'd0;
    end else begin
      starve  = 0;
      a       = bus.i_addr;
      m_we    = 1'b0;
      m_wdata = 32'd0;
    end
    m_bad  = ALIGN_EN && (a[1:0] != 2'b00);
    m_word = a[ADDR_W+1:2];
    m_rd   = m_bad ? 32'd0 : ref_mem[m_word];
    if (m_we && !m_bad) ref_mem[m_word] = m_wdata;
    m_active = 1'b1;
    m_arb    = cyc;
    free_at  = cyc + 4;
  endtask

  // Compare every DUT output for the current cycle against the reference.
  task automatic compare();
    bit en, ack_i, ack_d;
    en    = m_active && (cyc == m_arb + 1) && !m_bad;
    ack_i = m_active && (cyc == m_arb + 3) && !m_is_d;
    ack_d = m_active && (cyc == m_arb + 3) && m_is_d;
    check("mem_en", 32'(bus.mem_en), 32'(en));
    if (en) begin
      check("mem_we", 32'(bus.mem_we), 32'(m_we));
      check("mem_addr", 32'(bus.mem_addr), 32'(m_word));
      check("mem_wdata", bus.mem_wdata, m_wdata);
    end
    if (ack_i) exp_i_rdata = m_rd;
    if (ack_d && (m_bad || !m_we)) exp_d_rdata = m_rd;
    check("i_ack", 32'(bus.i_ack), 32'(ack_i));
    check("d_ack", 32'(bus.d_ack), 32'(ack_d));
    check("i_err", 32'(bus.i_err), 32'(ack_i && m_bad));
    check("d_err", 32'(bus.d_err), 32'(ack_d && m_bad));
    check("i_rdata", bus.i_rdata, exp_i_rdata);
    check("d_rdata", bus.d_rdata, exp_d_rdata);
    if (bus.i_ack === 1'b1) ack_order.push_back(0);
    if (bus.d_ack === 1'b1) ack_order.push_back(1);
    if (ack_i || ack_d) m_active = 1'b0;
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask

  task automatic run_until_ack(input bit want_d, input int budget, output int lat);
    bit seen = 1'b0;
    lat = 0;
    while (!seen && lat < budget) begin
      step();
      lat++;
      seen = want_d ? (bus.d_ack === 1'b1) : (bus.i_ack === 1'b1);
    end
    check(want_d ? "d_ack_seen" : "i_ack_seen", 32'(seen), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    int lat;
    int exp_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic [31:0] w;

    reset       = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    // Preload memory and its shadow while reset is held.
    for (int i = 0; i < WORDS; i++) begin
      w = (i == 5) ? 32'hE080_2001 : $urandom;
      ref_mem[i] = w;
      bd_we   = 1'b1;
      bd_idx  = ADDR_W'(i);
      bd_data = w;
      @(posedge clk);
      #1;
    end
    bd_we = 1'b0;

    // Reset state: every output must read 0.
    step();
    step();
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_i_rdata", bus.i_rdata, 32'd0);
    reset = 1'b0;

    // Single fetch of word 5 from byte address 0x14.
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h14;
    step();
    check("fetch_mem_en", 32'(bus.mem_en), 32'd1);
    check("fetch_mem_addr", 32'(bus.mem_addr), 32'd5);
    step();
    check("fetch_no_early_ack", 32'(bus.i_ack), 32'd0);
    step();
    check("fetch_ack", 32'(bus.i_ack), 32'd1);
    check("fetch_rdata", bus.i_rdata, 32'hE080_2001);
    bus.i_req = 1'b0;
    step();
    check("fetch_ack_one_cycle", 32'(bus.i_ack), 32'd0);
    check("fetch_rdata_held", bus.i_rdata, 32'hE080_2001);

    // Write 0x12345678 to byte 0x24, then read it back.
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h24;
    bus.d_wdata = 32'h1234_5678;
    step();
    check("wr_mem_we", 32'(bus.mem_we), 32'd1);
    check("wr_mem_addr", 32'(bus.mem_addr), 32'd9);
    step();
    step();
    check("wr_ack", 32'(bus.d_ack), 32'd1);
    check("wr_rdata_unchanged", bus.d_rdata, 32'd0);
    bus.d_we = 1'b0;
    run_until_ack(1'b1, 8, lat);
    check("rd_latency_after_done", 32'(lat), 32'd4);
    check("rd_rdata", bus.d_rdata, 32'h1234_5678);
    bus.d_req = 1'b0;
    step();

    // Held fetch request: one ack, next fetch arbitrated in cycle 4.
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h24;
    run_until_ack(1'b0, 8, lat);
    check("held_latency", 32'(lat), 32'd3);
    check("held_rdata", bus.i_rdata, 32'h1234_5678);
    step();
    check("held_no_second_ack", 32'(bus.i_ack), 32'd0);
    check("held_no_strobe_c4", 32'(bus.mem_en), 32'd0);
    step();
    check("held_strobe_c5", 32'(bus.mem_en), 32'd1);
    run_until_ack(1'b0, 8, lat);
    check("held_second_ack", 32'(lat), 32'd2);
    bus.i_req = 1'b0;
    step();

    // Contention with both requests held: D,D,D,D,I repeating.
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h14;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h24;
    ack_order.delete();
    repeat (40) step();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    check("starve_grant_count", 32'(ack_order.size()), 32'd10);
    for (int k = 0; k < 10 && k < ack_order.size(); k++)
      check($sformatf("starve_grant_%0d", k), 32'(ack_order[k]), 32'(exp_order[k]));
    step();

    // Reset during WAIT of a D read: nothing is acked.
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h24;
    ack_order.delete();
    step();
    step();
    reset     = 1'b1;
    bus.d_req = 1'b0;
    step();
    check("rst_mid_d_ack", 32'(bus.d_ack), 32'd0);
    check("rst_mid_d_rdata", bus.d_rdata, 32'd0);
    check("rst_mid_mem_en", 32'(bus.mem_en), 32'd0);
    reset = 1'b0;
    repeat (4) step();
    check("rst_mid_no_ack", 32'(ack_order.size()), 32'd0);
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h14;
    step();
    check("rst_mid_idle_strobe", 32'(bus.mem_en), 32'd1);
    run_until_ack(1'b0, 8, lat);
    check("rst_mid_fetch_lat", 32'(lat), 32'd2);
    bus.i_req = 1'b0;
    step();

    // Misaligned read of byte 0x26.
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h26;
    step();
    check("align_mem_en", 32'(bus.mem_en), ALIGN_EN ? 32'd0 : 32'd1);
    step();
    step();
    check("align_ack", 32'(bus.d_ack), 32'd1);
    check("align_err", 32'(bus.d_err), 32'(ALIGN_EN));
    check("align_rdata", bus.d_rdata, ALIGN_EN ? 32'd0 : 32'h1234_5678);
    bus.d_req = 1'b0;
    step();

    // Random traffic: each side raises a request, holds it until its ack.
    for (int n = 0; n < 3000; n++) begin
      if (bus.i_ack === 1'b1) bus.i_req = 1'b0;
      if (bus.d_ack === 1'b1) bus.d_req = 1'b0;
      if (!bus.i_req && $urandom_range(0, 2) == 0) begin
        bus.i_req  = 1'b1;
        bus.i_addr = rand_addr();
      end
      if (!bus.d_req && $urandom_range(0, 2) == 0) begin
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = rand_addr();
        bus.d_wdata = $urandom;
      end
      step();
    end
    if (bus.i_ack === 1'b1) bus.i_req = 1'b0;
    if (bus.d_ack === 1'b1) bus.d_req = 1'b0;
    repeat (8) begin
      step();
      if (bus.i_ack === 1'b1) bus.i_req = 1'b0;
      if (bus.d_ack === 1'b1) bus.d_req = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
